c_if_id_skid_register: RTL and testbench
========================================

# c_if_id_skid_register

Parametrised, elastic IF/ID control pipeline register. It carries a generic control payload from fetch to decode, by default {funct7b5, funct3, op}, using a valid/ready handshake with a two-entry skid buffer. The ready output is registered, so decode back-pressure never forms a combinational path into fetch. It inserts a NOP on flush or empty and keeps saturating stall and flush event counters for performance monitoring. It sits between the fetch-side decode-field extraction and the decode-stage control logic.

## Interface
Parameters:
- FIELD_W, 11: payload width. The default packing is {funct7b5, funct3[2:0], op[6:0]}.
- NOP_WORD, 11'h013: payload presented when no valid entry is held. It encodes funct7b5=0, funct3=000, op=0010011 (addi x0,x0,0).
- CNT_W, 16: width of each event counter.

Ports:
- clk, in, 1: clock. One clock domain, rising edge only.
- reset, in, 1: reset, synchronous and active-high.
- valid_F, in, 1: the fetch side offers payload_F.
- payload_F, in, FIELD_W: control payload from fetch.
- ready_F, out, 1: the register can accept this cycle. Driven directly from state flops.
- FlushD, in, 1: discard all held and incoming entries.
- StallD, in, 1: decode cannot consume payload_D this cycle.
- valid_D, out, 1: payload_D holds a real instruction.
- payload_D, out, FIELD_W: control payload to decode. Equals NOP_WORD whenever valid_D=0.
- stall_cnt, out, CNT_W: count of cycles with valid_D && StallD. Saturating.
- flush_cnt, out, CNT_W: count of cycles with FlushD=1. Saturating.

## Operation
Storage:
- main entry (payload_D, valid_D) and one skid entry.
- Per-cycle events: accept = valid_F && ready_F; consume = valid_D && !StallD.

State machine, where ready_F = (state != FULL):
- EMPTY:
  - accept → ONE, main <= payload_F.
  - otherwise EMPTY.
- ONE:
  - accept && consume → ONE, main <= payload_F.
  - accept && !consume → FULL, skid <= payload_F.
  - !accept && consume → EMPTY, main <= NOP_WORD.
  - otherwise hold.
- FULL:
  - consume → ONE, main <= skid.
  - otherwise hold. No accept is possible.

Flush:
- FlushD=1 has priority over every transition. The next state is EMPTY, main <= NOP_WORD, and the skid entry is invalidated.
- An entry offered on the flush cycle is dropped, even if ready_F=1.
- Held payloads are never reordered or duplicated. Output order equals accept order.

Counters:
- Each counter increments by 1 per qualifying cycle and holds at 2^CNT_W−1.
- Counters are cleared only by reset, not by FlushD.

## Timing
- Reset (synchronous, applied at the next rising edge with reset=1):
  - state=EMPTY, valid_D=0, payload_D=NOP_WORD, ready_F=1.
  - skid entry invalid; both counters 0.
- Reset dominates FlushD and any handshake in the same cycle. Reset asserted mid-operation discards all entries at that edge.
- Latency: an entry accepted at edge N appears on payload_D with valid_D=1 after edge N, provided the register was EMPTY, or ONE with consume at edge N.
- Throughput: one entry per cycle with StallD=0.
- ready_F falls one cycle after the first stalled accept (ONE→FULL). It rises the cycle after the first consume from FULL. No combinational path exists from StallD or FlushD to ready_F.
- Simultaneous FlushD and StallD: the flush wins, and stall_cnt still increments if valid_D=1 that cycle.
- Flush recovery: ready_F=1 and valid_D=0 in the cycle after FlushD.

## Structure
- Shared package c_pipeline_pkg holds:
  - state enum {EMPTY, ONE, FULL} (2-bit).
  - default NOP constant C_NOP_CTRL = 11'h013.
  - field-packing localparams for the funct7b5/funct3/op offsets.
- Sub-module c_saturating_counter (parameter W; ports clk, reset, inc, count), instantiated twice for stall_cnt and flush_cnt.
- Expected RTL size: ~150–250 lines including the counter.

## Test plan
- Reset then idle: after reset, valid_D=0, payload_D=11'h013, ready_F=1, counters 0.
- Streaming: 4 back-to-back accepts of 11'h033, 11'h063, 11'h103, 11'h413 with StallD=0. These emerge on consecutive cycles, one cycle after each accept, with ready_F constantly 1.
- Back-pressure:
  - Stimulus: accept A=11'h033, then raise StallD for 3 cycles while offering B=11'h063, then C.
  - Required response: B goes into skid and ready_F=0 from the next cycle. C is not accepted. stall_cnt=3.
  - After StallD drops, the output sequence is A, B, C with no loss or duplicate.
- Flush while FULL: FlushD=1 with valid_F=1 offering 11'h6F. Next cycle valid_D=0, payload_D=11'h013, ready_F=1, flush_cnt=1, and 11'h6F never appears.
- Counter saturation with CNT_W=3: hold valid_D=1, StallD=1 for 10 cycles. stall_cnt reaches 7 and holds at 7.
- Reset mid-operation: assert reset while FULL with FlushD=1. Next cycle all outputs match the reset values and both counters read 0.

Source files
------------

// File: rtl/c_pipeline_pkg.sv
// Shared pipeline definitions: skid-buffer state encoding and IF/ID control-field packing.
package c_pipeline_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam int unsigned C_CTRL_W       = 11;
    localparam int unsigned C_OP_LSB       = 0;
    localparam int unsigned C_OP_W         = 7;
    localparam int unsigned C_FUNCT3_LSB   = 7;
    localparam int unsigned C_FUNCT3_W     = 3;
    localparam int unsigned C_FUNCT7B5_BIT = 10;

    // addi x0,x0,0 : funct7b5=0, funct3=000, op=0010011
    localparam logic [C_CTRL_W-1:0] C_NOP_CTRL = 11'h013;

    typedef struct packed {
        logic                  funct7b5;
        logic [C_FUNCT3_W-1:0] funct3;
        logic [C_OP_W-1:0]     op;
    } ctrl_fields_t;

    // Pack decode fields into the default control word layout.
    function automatic logic [C_CTRL_W-1:0] pack_ctrl(
        input logic                  funct7b5,
        input logic [C_FUNCT3_W-1:0] funct3,
        input logic [C_OP_W-1:0]     op
    );
        ctrl_fields_t f;
        f.funct7b5 = funct7b5;
        f.funct3   = funct3;
        f.op       = op;
        return C_CTRL_W'(f);
    endfunction

endpackage

// File: rtl/c_saturating_counter.sv
// Event counter that counts qualifying cycles and sticks at its maximum value.
module c_saturating_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    // Increment on each qualifying cycle until saturated; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/c_if_id_skid_register.sv
// Elastic IF/ID control register: two-entry skid buffer with registered ready,
// NOP insertion on flush/empty, and saturating stall/flush event counters.
module c_if_id_skid_register
    import c_pipeline_pkg::*;
#(
    parameter int unsigned               FIELD_W  = 11,
    parameter logic [FIELD_W-1:0]        NOP_WORD = FIELD_W'(C_NOP_CTRL),
    parameter int unsigned               CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_F,
    input  logic [FIELD_W-1:0] payload_F,
    output logic               ready_F,
    input  logic               FlushD,
    input  logic               StallD,
    output logic               valid_D,
    output logic [FIELD_W-1:0] payload_D,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    skid_state_e        state_q;
    skid_state_e        state_d;
    logic [FIELD_W-1:0] skid_q;
    logic [FIELD_W-1:0] skid_d;
    logic [FIELD_W-1:0] main_d;
    logic               valid_d;
    logic               ready_d;
    logic               accept_c;
    logic               consume_c;

    // Handshake events; ready_F and valid_D are both flop outputs.
    assign accept_c  = valid_F && ready_F;
    assign consume_c = valid_D && !StallD;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every handshake transition.
    always_comb begin
        state_d = state_q;
        if (FlushD) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept_c) state_d = ONE;
                ONE: begin
                    if (accept_c && !consume_c)      state_d = FULL;
                    else if (!accept_c && consume_c) state_d = EMPTY;
                end
                FULL:  if (consume_c) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Datapath next values for main/skid entries and the registered ready.
    always_comb begin
        main_d  = payload_D;
        valid_d = valid_D;
        skid_d  = skid_q;
        if (FlushD) begin
            main_d  = NOP_WORD;
            valid_d = 1'b0;
            skid_d  = NOP_WORD;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        main_d  = payload_F;
                        valid_d = 1'b1;
                    end
                end
                ONE: begin
                    if (accept_c && consume_c) begin
                        main_d = payload_F;
                    end else if (accept_c) begin
                        skid_d = payload_F;
                    end else if (consume_c) begin
                        main_d  = NOP_WORD;
                        valid_d = 1'b0;
                    end
                end
                FULL: begin
                    if (consume_c) begin
                        main_d = skid_q;
                        skid_d = NOP_WORD;
                    end
                end
                default: begin
                    main_d  = NOP_WORD;
                    valid_d = 1'b0;
                end
            endcase
        end
        ready_d = (state_d != FULL);
    end

    // Main entry, skid entry and ready flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            payload_D <= NOP_WORD;
            valid_D   <= 1'b0;
            skid_q    <= NOP_WORD;
            ready_F   <= 1'b1;
        end else begin
            payload_D <= main_d;
            valid_D   <= valid_d;
            skid_q    <= skid_d;
            ready_F   <= ready_d;
        end
    end

    c_saturating_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (valid_D && StallD),
        .count (stall_cnt)
    );

    c_saturating_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (FlushD),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_c_if_id_skid_register.sv
// Scoreboard bench for the IF/ID skid register: driver pushes expected payloads,
// monitor pops and compares on every consume.
module tb_c_if_id_skid_register;

    localparam logic [10:0] NOP = 11'h013;

    logic        clk;
    logic        reset;
    logic        valid_F;
    logic [10:0] payload_F;
    logic        FlushD;
    logic        StallD;
    logic        ready_F;
    logic        valid_D;
    logic [10:0] payload_D;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        ready_F3;
    logic        valid_D3;
    logic [10:0] payload_D3;
    logic [2:0]  stall_cnt3;
    logic [2:0]  flush_cnt3;

    int total;
    int bad;
    logic [10:0] exp_q[$];

    c_if_id_skid_register dut (
        .clk(clk), .reset(reset), .valid_F(valid_F), .payload_F(payload_F),
        .ready_F(ready_F), .FlushD(FlushD), .StallD(StallD), .valid_D(valid_D),
        .payload_D(payload_D), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    c_if_id_skid_register #(.CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .valid_F(valid_F), .payload_F(payload_F),
        .ready_F(ready_F3), .FlushD(FlushD), .StallD(StallD), .valid_D(valid_D3),
        .payload_D(payload_D3), .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: on a consume cycle pop the next expected payload; idle output must be NOP.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && !FlushD) begin
                if (valid_D && !StallD) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 32'(payload_D), 32'h7FF);
                    end else begin
                        chk("payload_order", 32'(payload_D), 32'(exp_q.pop_front()));
                    end
                end else if (!valid_D) begin
                    chk("idle_nop", 32'(payload_D), 32'(NOP));
                end
            end
        end
    end

    initial begin
        logic [10:0] stream [4];
        stream[0] = 11'h033; stream[1] = 11'h063; stream[2] = 11'h103; stream[3] = 11'h413;
        total = 0;
        bad   = 0;
        reset = 1'b1; valid_F = 1'b0; payload_F = '0; FlushD = 1'b0; StallD = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();

        // Reset then idle
        chk("rst_valid_D", 32'(valid_D), 32'd0);
        chk("rst_payload_D", 32'(payload_D), 32'(NOP));
        chk("rst_ready_F", 32'(ready_F), 32'd1);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);

        // Streaming: one accept per cycle, ready stays high
        for (int i = 0; i < 4; i++) begin
            valid_F = 1'b1; payload_F = stream[i];
            exp_q.push_back(stream[i]);
            cyc();
            chk("stream_valid_D", 32'(valid_D), 32'd1);
            chk("stream_payload_D", 32'(payload_D), 32'(stream[i]));
            chk("stream_ready_F", 32'(ready_F), 32'd1);
        end
        valid_F = 1'b0;
        cyc();
        chk("stream_drained", 32'(valid_D), 32'd0);

        // Back-pressure: A held, B into skid, C refused until drain
        valid_F = 1'b1; payload_F = 11'h033; exp_q.push_back(11'h033);
        cyc();
        StallD = 1'b1; payload_F = 11'h063; exp_q.push_back(11'h063);
        cyc();
        chk("bp_ready_low1", 32'(ready_F), 32'd0);
        payload_F = 11'h0E3; exp_q.push_back(11'h0E3);
        cyc();
        chk("bp_ready_low2", 32'(ready_F), 32'd0);
        chk("bp_hold_A", 32'(payload_D), 32'h033);
        cyc();
        chk("bp_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("bp_ready_low3", 32'(ready_F), 32'd0);
        StallD = 1'b0;
        cyc();
        chk("bp_ready_rise", 32'(ready_F), 32'd1);
        chk("bp_out_B", 32'(payload_D), 32'h063);
        cyc();
        chk("bp_out_C", 32'(payload_D), 32'h0E3);
        valid_F = 1'b0;
        cyc();
        chk("bp_stall_cnt_hold", 32'(stall_cnt), 32'd3);
        chk("bp_empty", 32'(valid_D), 32'd0);

        // Flush while FULL, with a new entry offered in the flush cycle
        valid_F = 1'b1; payload_F = 11'h0AA;
        cyc();
        StallD = 1'b1; payload_F = 11'h0BB;
        cyc();
        chk("fl_full", 32'(ready_F), 32'd0);
        FlushD = 1'b1; payload_F = 11'h06F;
        cyc();
        FlushD = 1'b0; StallD = 1'b0; valid_F = 1'b0;
        chk("fl_valid_D", 32'(valid_D), 32'd0);
        chk("fl_payload_D", 32'(payload_D), 32'(NOP));
        chk("fl_ready_F", 32'(ready_F), 32'd1);
        chk("fl_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("fl_stall_cnt", 32'(stall_cnt), 32'd5);
        cyc(); cyc();
        chk("fl_no_6F", 32'(valid_D), 32'd0);

        // Counter saturation on the CNT_W=3 instance
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("sat_rst", 32'(stall_cnt3), 32'd0);
        valid_F = 1'b1; payload_F = 11'h013; exp_q.push_back(11'h013);
        cyc();
        valid_F = 1'b0; StallD = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("sat_cnt3", 32'(stall_cnt3), (i + 1 < 7) ? 32'(i + 1) : 32'd7);
            chk("sat_cnt16", 32'(stall_cnt), 32'(i + 1));
        end
        chk("sat_valid3", 32'(valid_D3), 32'd1);
        StallD = 1'b0;
        cyc();
        chk("sat_drained", 32'(valid_D), 32'd0);

        // Reset mid-operation while FULL with FlushD asserted
        valid_F = 1'b1; payload_F = 11'h123;
        cyc();
        StallD = 1'b1; payload_F = 11'h234;
        cyc();
        chk("rm_full", 32'(ready_F), 32'd0);
        reset = 1'b1; FlushD = 1'b1; payload_F = 11'h345;
        cyc();
        reset = 1'b0; FlushD = 1'b0; StallD = 1'b0; valid_F = 1'b0;
        chk("rm_valid_D", 32'(valid_D), 32'd0);
        chk("rm_payload_D", 32'(payload_D), 32'(NOP));
        chk("rm_ready_F", 32'(ready_F), 32'd1);
        chk("rm_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rm_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rm_flush_cnt3", 32'(flush_cnt3), 32'd0);
        chk("rm_ready_F3", 32'(ready_F3), 32'd1);
        chk("rm_payload_D3", 32'(payload_D3), 32'(NOP));
        cyc(); cyc();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
